instr_dispatch_ctrl: RTL and testbench

INSTR_DISPATCH_CTRL -- requirements
Module: instr_dispatch_ctrl

---
 rtl/instr_dispatch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_instr_dispatch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch_ctrl.sv
// Instruction dispatch controller: buffers received instruction words in a
// FIFO, issues them one at a time to the core, waits for completion (or a
// timeout), then hands the core's register-dump word to the transmitter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing outstanding; issue as soon as the FIFO is non-empty
// ISSUE     | instr_valid strobe for one cycle, FIFO head popped
// WAIT_DONE | waiting for core_done; timer counts up towards TIMEOUT
// DUMP      | reg_dump captured into tx_data
// WAIT_TX   | tx_valid held until the transmitter accepts the word
module instr_dispatch_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rx_valid,
  input  logic [15:0]              rx_data,
  output logic                     instr_valid,
  output logic [15:0]              instr,
  input  logic                     core_done,
  input  logic [19:0]              reg_dump,
  output logic                     tx_valid,
  output logic [19:0]              tx_data,
  input  logic                     tx_ready,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // The timer expires on the cycle it would step onto TIMEOUT.
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_DUMP,
    S_WAIT_TX
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            instr_valid_q, instr_valid_d;
  logic [15:0]     instr_q, instr_d;
  logic            tx_valid_q, tx_valid_d;
  logic [19:0]     tx_data_q, tx_data_d;
  logic [15:0]     timer_q, timer_d;
  logic            overflow_q, timeout_err_q;
  logic            push, pop, drop, timeout_evt;

  // FIFO push/pop qualification; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop   = (state_q == S_ISSUE);
    push  = rx_valid && ((count_q != CW'(DEPTH)) || pop);
    drop  = rx_valid && !push;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // FIFO storage; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // FIFO pointers and occupancy; pointer width gives the modulo-DEPTH wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Next-state and registered-output logic for the dispatch sequence.
  always_comb begin
    state_d       = state_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    timer_d       = timer_q;
    timeout_evt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d       = S_ISSUE;
          instr_valid_d = 1'b1;
          instr_d       = mem_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + 16'd1;
        if (core_done) begin
          state_d = S_DUMP;
        end else if (timer_q == TMR_LAST) begin
          timeout_evt = 1'b1;
          state_d     = S_DUMP;
        end
      end
      S_DUMP: begin
        tx_data_d  = reg_dump;
        tx_valid_d = 1'b1;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, output and timer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      timer_q       <= timer_d;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (drop)         overflow_q <= 1'b1;
      else if (clr_err) overflow_q <= 1'b0;
      if (timeout_evt)  timeout_err_q <= 1'b1;
      else if (clr_err) timeout_err_q <= 1'b0;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Directed bench for instr_dispatch_ctrl with DEPTH=8, TIMEOUT=255.
module tb_instr_dispatch_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic        core_done;
  logic [19:0] reg_dump;
  logic        tx_valid;
  logic [19:0] tx_data;
  logic        tx_ready;
  logic        clr_err;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        timeout_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  instr_dispatch_ctrl #(.DEPTH(8), .TIMEOUT(255)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .core_done   (core_done),
    .reg_dump    (reg_dump),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .clr_err     (clr_err),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_instr"},       32'(instr),       32'h0);
    check({tag, "_tx_valid"},    32'(tx_valid),    32'h0);
    check({tag, "_tx_data"},     32'(tx_data),     32'h0);
    check({tag, "_fifo_count"},  32'(fifo_count),  32'h0);
    check({tag, "_overflow"},    32'(overflow),    32'h0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    check({tag, "_busy"},        32'(busy),        32'h0);
  endtask

  // Bounded wait for the next issue strobe.
  task automatic wait_issue(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) break;
      step();
    end
    check("issue_seen", 32'(instr_valid), 32'h1);
  endtask

  // Issue -> core_done on first WAIT_DONE cycle -> immediate tx handshake.
  task automatic run_one(input logic [15:0] exp_instr);
    wait_issue(20);
    check("order", 32'(instr), 32'(exp_instr));
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    check("run_tx_valid", 32'(tx_valid), 32'h1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    core_done = 1'b0;
    reg_dump  = '0;
    tx_ready  = 1'b0;
    clr_err   = 1'b0;
    #1;
    check_reset_outputs("rst");
    step();
    step();
    reset_n = 1'b1;
    step();
    check_reset_outputs("post_rst");

    // Single instruction: rx at cycle 0, issue at 2, done at 5, tx from 7.
    rx_valid = 1'b1;
    rx_data  = 16'h1234;
    step();
    rx_valid = 1'b0;
    check("t1_count1", 32'(fifo_count), 32'h1);
    check("t1_not_yet", 32'(instr_valid), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);
    step();
    check("t1_issue", 32'(instr_valid), 32'h1);
    check("t1_instr", 32'(instr), 32'h1234);
    check("t1_busy", 32'(busy), 32'h1);
    step();
    check("t1_strobe_1cyc", 32'(instr_valid), 32'h0);
    check("t1_instr_hold", 32'(instr), 32'h1234);
    check("t1_popped", 32'(fifo_count), 32'h0);
    step();
    step();
    core_done = 1'b1;
    reg_dump  = 20'hABCDE;
    step();
    core_done = 1'b0;
    tx_ready  = 1'b1;
    check("t1_dump_txv0", 32'(tx_valid), 32'h0);
    step();
    tx_ready = 1'b0;
    reg_dump = 20'h11111;
    check("t1_txv", 32'(tx_valid), 32'h1);
    check("t1_txd", 32'(tx_data), 32'hABCDE);
    step();
    step();
    check("t1_txd_stable", 32'(tx_data), 32'hABCDE);
    check("t1_txv_held", 32'(tx_valid), 32'h1);
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("t1_txv_drop", 32'(tx_valid), 32'h0);
    check("t1_busy_done", 32'(busy), 32'h0);

    // core_done while IDLE has no effect.
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("idle_done_busy", 32'(busy), 32'h0);
    step();
    check("idle_done_txv", 32'(tx_valid), 32'h0);

    // Timeout: WAIT_DONE entry at cycle E, dump state at E+255.
    reg_dump = 20'h0F00D;
    rx_valid = 1'b1;
    rx_data  = 16'h0BAD;
    step();
    rx_valid = 1'b0;
    step();
    check("to_issue", 32'(instr), 32'h0BAD);
    step();
    for (int i = 0; i < 254; i++) step();
    check("to_not_yet", 32'(timeout_err), 32'h0);
    check("to_still_wait", 32'(tx_valid), 32'h0);
    step();
    check("to_err_set", 32'(timeout_err), 32'h1);
    check("to_dump_txv0", 32'(tx_valid), 32'h0);
    step();
    check("to_txv", 32'(tx_valid), 32'h1);
    check("to_txd", 32'(tx_data), 32'h0F00D);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_clr", 32'(timeout_err), 32'h0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("to_idle", 32'(busy), 32'h0);

    // core_done on the expiry cycle wins over the timeout.
    rx_valid = 1'b1;
    rx_data  = 16'h0C0D;
    step();
    rx_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 254; i++) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("edge_no_err", 32'(timeout_err), 32'h0);
    step();
    check("edge_txv", 32'(tx_valid), 32'h1);
    check("edge_no_err2", 32'(timeout_err), 32'h0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;

    // Overflow: 10 back-to-back words, core held off.
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = 16'hA000 + 16'(i);
      if (i == 2) begin
        check("ov_issue", 32'(instr_valid), 32'h1);
        check("ov_first", 32'(instr), 32'hA000);
      end
      if (i == 9) begin
        check("ov_full", 32'(fifo_count), 32'h8);
        check("ov_not_yet", 32'(overflow), 32'h0);
      end
      step();
    end
    rx_valid = 1'b0;
    check("ov_peak", 32'(fifo_count), 32'h8);
    check("ov_flag", 32'(overflow), 32'h1);
    clr_err   = 1'b1;
    core_done = 1'b1;
    step();
    clr_err   = 1'b0;
    core_done = 1'b0;
    check("ov_clr", 32'(overflow), 32'h0);
    check("ov_count_kept", 32'(fifo_count), 32'h8);
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;

    // Push during the pop cycle at a full FIFO.
    wait_issue(20);
    rx_valid = 1'b1;
    rx_data  = 16'hB000;
    check("pp_order", 32'(instr), 32'hA001);
    step();
    rx_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'h8);
    check("pp_no_ov", 32'(overflow), 32'h0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;

    // Backpressure: transmitter stalls for 50 cycles.
    wait_issue(20);
    check("bp_order", 32'(instr), 32'hA002);
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    reg_dump  = 20'h22222;
    step();
    reg_dump = 20'h33333;
    for (int i = 0; i < 50; i++) begin
      check("bp_txv", 32'(tx_valid), 32'h1);
      check("bp_txd", 32'(tx_data), 32'h22222);
      check("bp_no_issue", 32'(instr_valid), 32'h0);
      check("bp_count", 32'(fifo_count), 32'h7);
      step();
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    run_one(16'hA003);
    run_one(16'hA004);
    run_one(16'hA005);

    // Reset in WAIT_TX with three words still queued.
    wait_issue(20);
    check("rs_order", 32'(instr), 32'hA006);
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    check("rs_in_wait_tx", 32'(tx_valid), 32'h1);
    check("rs_queued", 32'(fifo_count), 32'h3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rs_async");
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rs_no_issue", 32'(instr_valid), 32'h0);
      check("rs_no_tx", 32'(tx_valid), 32'h0);
      check("rs_empty", 32'(fifo_count), 32'h0);
    end

    // rx on the first edge after reset release is accepted.
    reset_n = 1'b0;
    step();
    reset_n  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 16'h5A5A;
    step();
    rx_valid = 1'b0;
    check("rel_count", 32'(fifo_count), 32'h1);
    step();
    check("rel_issue", 32'(instr_valid), 32'h1);
    check("rel_instr", 32'(instr), 32'h5A5A);
    step();
    core_done = 1'b1;
    reg_dump  = 20'h4C4C4;
    step();
    core_done = 1'b0;
    step();
    check("rel_txd", 32'(tx_data), 32'h4C4C4);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("rel_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
